// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: sync/deglitch, 11-bit frame check, byte FIFO.
// Optional prefix folding (E0/F0) enabled by defining PS2_RX_PREFIX_EN.
module ps2_host_rx #(
  parameter int unsigned FILTER    = 8,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_ext,
  output logic       rx_rel,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int PW    = FIFO_BITS + 1;
`ifdef PS2_RX_PREFIX_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_e;

  // bit 1 = clock line, bit 0 = data line
  logic [1:0] s1_q, s2_q, flt_q;
  logic [7:0] fcnt_q [2];
  logic       clk_fd_q, fall_q;

  state_e      state_q, state_d;
  logic [7:0]  sh_q;
  logic [2:0]  bcnt_q;
  logic        par_q, mism_q;
  logic [15:0] tout_q;
  logic        ext_q, rel_q;

  logic [PW-1:0] wr_q, rd_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] entry, head;

  logic dat, tout_hit, good, is_pfx;
  logic full, empty, push, pop;

  assign dat      = flt_q[0];
  assign tout_hit = (state_q != S_IDLE) && !fall_q
                    && (tout_q == TIMEOUT);

  // Two-flop synchronisers and hold-time filters on both lines
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      flt_q     <= 2'b11;
      fcnt_q[0] <= 8'd0;
      fcnt_q[1] <= 8'd0;
    end else begin
      s1_q <= {ps2_clk, ps2_data};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] != flt_q[i]) begin
          if (fcnt_q[i] == 8'(FILTER - 1)) begin
            flt_q[i]  <= s2_q[i];
            fcnt_q[i] <= 8'd0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 8'd1;
          end
        end else begin
          fcnt_q[i] <= 8'd0;
        end
      end
    end
  end

  // Registered falling-edge pulse of the filtered clock
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_fd_q <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      clk_fd_q <= flt_q[1];
      fall_q   <= clk_fd_q & ~flt_q[1];
    end
  end

  // Frame state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Frame next-state logic; timeout aborts any non-idle state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fall_q && !dat) state_d = S_DATA;
      S_DATA: begin
        if (tout_hit)                        state_d = S_IDLE;
        else if (fall_q && bcnt_q == 3'd7)   state_d = S_PAR;
      end
      S_PAR: begin
        if (tout_hit)    state_d = S_IDLE;
        else if (fall_q) state_d = S_STOP;
      end
      S_STOP: begin
        if (tout_hit || fall_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame outcome pulses
  always_comb begin
    err_frame   = 1'b0;
    err_parity  = 1'b0;
    err_timeout = tout_hit;
    good        = 1'b0;
    if (fall_q) begin
      case (state_q)
        S_IDLE: err_frame = dat;
        S_STOP: begin
          if (!dat)        err_frame  = 1'b1;
          else if (mism_q) err_parity = 1'b1;
          else             good       = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PS2_RX_PREFIX_EN
  assign is_pfx = (sh_q == 8'hE0) || (sh_q == 8'hF0);
  assign entry  = {ext_q, rel_q, sh_q};
`else
  assign is_pfx = 1'b0;
  assign entry  = sh_q;
`endif

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[FIFO_BITS] != rd_q[FIFO_BITS])
                    && (wr_q[FIFO_BITS-1:0] == rd_q[FIFO_BITS-1:0]);
  assign pop      = rx_rd && !empty;
  assign push     = good && !is_pfx && (!full || rx_rd);
  assign overflow = good && !is_pfx && full && !rx_rd;

  // Shift register, parity, timeout counter and prefix flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sh_q   <= 8'd0;
      bcnt_q <= 3'd0;
      par_q  <= 1'b0;
      mism_q <= 1'b0;
      tout_q <= 16'd0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE || fall_q) tout_q <= 16'd0;
      else if (tout_q != TIMEOUT)      tout_q <= tout_q + 16'd1;
      if (fall_q) begin
        case (state_q)
          S_IDLE: begin
            bcnt_q <= 3'd0;
            par_q  <= 1'b1;
            mism_q <= 1'b0;
          end
          S_DATA: begin
            sh_q   <= {dat, sh_q[7:1]};
            bcnt_q <= bcnt_q + 3'd1;
            if (dat) par_q <= ~par_q;
          end
          S_PAR:   mism_q <= (dat != par_q);
          default: ;
        endcase
      end
      if (good && is_pfx) begin
        if (sh_q == 8'hE0) ext_q <= 1'b1;
        else               rel_q <= 1'b1;
      end else if (good) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_q[FIFO_BITS-1:0]] <= entry;
  end

  assign head     = mem_q[rd_q[FIFO_BITS-1:0]];
  assign rx_empty = empty;
  assign rx_data  = empty ? 8'd0 : head[7:0];
`ifdef PS2_RX_PREFIX_EN
  assign rx_ext = !empty && head[9];
  assign rx_rel = !empty && head[8];
`else
  assign rx_ext = 1'b0;
  assign rx_rel = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Randomised bench for ps2_host_rx with a queue-based reference model.
// Follows PS2_RX_PREFIX_EN the same way the design does.
module tb_ps2_host_rx;

  localparam int F  = 8;
  localparam int H  = 40;
  localparam int TO = 1000;
`ifdef PS2_RX_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_ext, rx_rel;
  logic       err_parity, err_frame, err_timeout, overflow;

  ps2_host_rx #(
    .FILTER(F), .TIMEOUT(16'(TO)), .FIFO_BITS(3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_ext(rx_ext), .rx_rel(rx_rel),
    .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [9:0] q[$];
  bit pend_e = 0;
  bit pend_r = 0;
  int exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovf = 0;
  int got_par = 0, got_frm = 0, got_to = 0, got_ovf = 0;
  int to_cyc = 0;
  int t_last_fall = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Compare process: head vs model every cycle, pulse counting
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (err_parity) got_par++;
      if (err_frame)  got_frm++;
      if (overflow)   got_ovf++;
      if (err_timeout) begin
        got_to++;
        to_cyc = cyc;
      end
      if (!rx_empty && q.size() > 0)
        chk("head", int'({rx_ext, rx_rel, rx_data}), int'(q[0]));
      if (rx_rd && !rx_empty) begin
        if (q.size() > 0) void'(q.pop_front());
        else chk("pop_model_occupancy", q.size(), 1);
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nf,
                           input bit rd_stop);
    for (int i = 0; i < nf; i++) begin
      ps2_data = bits[i];
      cyc_n(H);
      ps2_clk = 1'b0;
      t_last_fall = cyc;
      if (rd_stop && i == 10) begin
        cyc_n(3 + F);
        rx_rd = 1'b1;
        cyc_n(1);
        rx_rd = 1'b0;
        cyc_n(H - 4 - F);
      end else begin
        cyc_n(H);
      end
      ps2_clk = 1'b1;
    end
    cyc_n(H / 2);
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bp,
                             input bit bs);
    if (bs) exp_frm++;
    else if (bp) exp_par++;
    else if (PFX && (b == 8'hE0 || b == 8'hF0)) begin
      if (b == 8'hE0) pend_e = 1;
      else            pend_r = 1;
    end else begin
      if (q.size() >= 8) exp_ovf++;
      else q.push_back({pend_e, pend_r, b});
      pend_e = 0;
      pend_r = 0;
    end
  endtask

  task automatic post_check();
    chk("empty_vs_model", int'(rx_empty), int'(q.size() == 0));
    chk("err_parity_count", got_par, exp_par);
    chk("err_frame_count", got_frm, exp_frm);
    chk("err_timeout_count", got_to, exp_to);
    chk("overflow_count", got_ovf, exp_ovf);
  endtask

  task automatic frame(input logic [7:0] b, input bit bp,
                       input bit bs, input bit rd_stop);
    logic p;
    p = ~(^b) ^ bp;
    send_bits({~bs, p, b, 1'b0}, 11, rd_stop);
    cyc_n(F + 20);
    model_frame(b, bp, bs);
    post_check();
  endtask

  task automatic pop_check(input logic [9:0] exp);
    @(negedge clk_sys);
    chk("pop_head", int'({rx_ext, rx_rel, rx_data}), int'(exp));
    chk("pop_nonempty", int'(rx_empty), 0);
    @(posedge clk_sys);
    #1 rx_rd = 1'b1;
    @(posedge clk_sys);
    #1 rx_rd = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [7:0] b;
    int r;
    cyc_n(5);
    reset = 1'b0;
    cyc_n(2);
    chk("rst_empty", int'(rx_empty), 1);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_flags", int'({rx_ext, rx_rel}), 0);
    chk("rst_pulses",
        int'({err_parity, err_frame, err_timeout, overflow}), 0);

    // basic byte
    frame(8'h1C, 0, 0, 0);
    chk("lit_1c_data", int'(rx_data), 'h1C);
    chk("lit_1c_empty", int'(rx_empty), 0);
    pop_check(10'h01C);
    cyc_n(2);
    chk("lit_after_pop_empty", int'(rx_empty), 1);

    // parity error, stop error, start error
    frame(8'h1C, 1, 0, 0);
    chk("lit_par_count", got_par, 1);
    frame(8'h1C, 0, 1, 0);
    chk("lit_frm_count", got_frm, 1);
    send_bits(11'h7FF, 1, 0);
    cyc_n(F + 20);
    exp_frm++;
    post_check();

    // timeout after the 4th data bit, then recovery
    send_bits({2'b11, 8'h5A, 1'b0}, 5, 0);
    cyc_n(1100);
    exp_to++;
    post_check();
    d = to_cyc - t_last_fall;
    n_cmp++;
    if (d < TO || d > TO + F + 8) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d expected %0d..%0d",
               d, TO, TO + F + 8);
    end
    frame(8'h5A, 0, 0, 0);
    pop_check(10'h05A);

    // overflow on the 9th byte
    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, 0);
    chk("lit_ovf_once", got_ovf, 1);
    for (int i = 1; i <= 8; i++) pop_check(10'(i));
    cyc_n(2);
    chk("lit_ovf_drained", int'(rx_empty), 1);

    // full FIFO, pop in the stop-bit evaluation cycle
    for (int i = 0; i < 8; i++) frame(8'h40 + 8'(i), 0, 0, 0);
    frame(8'h33, 0, 0, 1);
    chk("lit_full_rd_no_ovf", got_ovf, 1);
    for (int i = 1; i < 8; i++) pop_check(10'h040 + 10'(i));
    pop_check(10'h033);
    cyc_n(2);
    chk("lit_full_rd_drained", int'(rx_empty), 1);

    // prefix sequence
    frame(8'hE0, 0, 0, 0);
    frame(8'hF0, 0, 0, 0);
    frame(8'h75, 0, 0, 0);
    frame(8'h1C, 0, 0, 0);
    if (PFX) begin
      pop_check(10'h375);
      pop_check(10'h01C);
    end else begin
      pop_check(10'h0E0);
      pop_check(10'h0F0);
      pop_check(10'h075);
      pop_check(10'h01C);
    end
    cyc_n(2);
    chk("lit_prefix_drained", int'(rx_empty), 1);

    // randomised frames with occasional errors and reads
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r == 2) b = 8'hE0;
      if (r == 3) b = 8'hF0;
      frame(b, r == 0, r == 1, 0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0)
        pop_check(q[0]);
    end
    while (q.size() > 0) pop_check(q[0]);
    cyc_n(2);
    chk("rand_drained", int'(rx_empty), 1);

    // reset mid-frame with data in the FIFO
    frame(8'hA5, 0, 0, 0);
    send_bits({2'b11, 8'h3C, 1'b0}, 4, 0);
    ps2_data = 1'b1;
    reset = 1'b1;
    cyc_n(3);
    reset = 1'b0;
    q.delete();
    pend_e = 0;
    pend_r = 0;
    cyc_n(2);
    chk("midrst_empty", int'(rx_empty), 1);
    chk("midrst_data", int'(rx_data), 0);
    frame(8'h5A, 0, 0, 0);
    pop_check(10'h05A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
PS/2 host-side receiver. It decodes the device-to-host serial stream (the ps2_kbd_clk/ps2_kbd_data or ps2_mouse_clk/ps2_mouse_data pair) into bytes for the C64 keyboard/mouse logic. Clock and data are synchronised and deglitched, and the 11-bit frame is checked. Good bytes go into a small FIFO that the core pops with a read strobe. One instance is used per PS/2 channel.

Parameters:
FILTER, 8, number of consecutive clk_sys samples a synchronised line must hold before the filtered value changes (1..255).
TIMEOUT, 16'd50000, clk_sys cycles allowed between falling edges inside a frame before the frame is aborted.
FIFO_BITS, 3, log2 of FIFO depth (depth 8 by default).

Ports:
clk_sys  in  1  system clock; all logic on posedge.
reset  in  1  synchronous reset, active-high.
ps2_clk  in  1  PS/2 clock line, asynchronous to clk_sys.
ps2_data  in  1  PS/2 data line, asynchronous to clk_sys.
rx_rd  in  1  pop strobe; one entry is removed per cycle while high and not empty.
rx_data  out  8  head-of-FIFO byte; valid while rx_empty=0.
rx_empty  out  1  FIFO empty.
rx_ext  out  1  head entry carried an E0 prefix (feature only; otherwise 0).
rx_rel  out  1  head entry carried an F0 prefix (feature only; otherwise 0).
err_parity  out  1  1-cycle pulse: frame discarded for a parity error.
err_frame  out  1  1-cycle pulse: start bit was 1 or stop bit was 0.
err_timeout  out  1  1-cycle pulse: frame aborted by timeout.
overflow  out  1  1-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset values:
  - Outputs: rx_empty=1; rx_data=0; rx_ext=0; rx_rel=0; all error pulses and overflow 0.
  - Internal: FIFO pointers 0, state IDLE, both filtered lines 1, timeout counter 0, prefix flags 0.
  - Reset asserted mid-frame discards the partial frame and the FIFO contents.
- Synchronisation and filtering:
  - Two-flop synchroniser on each line.
  - Per-line counter: when the synchronised value differs from the filtered value for FILTER consecutive cycles, the filtered value takes it.
  - A fall_edge pulse is generated when filtered clk goes 1->0.
- States:
  - IDLE: on fall_edge, sample data. If data=0 go to DATA with bit_cnt=0 and parity=1. If data=1 pulse err_frame and stay in IDLE.
  - DATA: on each fall_edge, shift data into bit 7 of the shift register (LSB first); if data=1, toggle parity. After the 8th bit go to PARITY.
  - PARITY: on fall_edge, compare data with the parity register. Set the mismatch flag if they differ. Go to STOP.
  - STOP: on fall_edge, handle the stop bit in priority order, then return to IDLE:
    1. data=0 -> pulse err_frame.
    2. mismatch set -> pulse err_parity.
    3. FIFO full and rx_rd=0 -> pulse overflow, drop the byte.
    4. Otherwise push the byte.
- Timeout:
  - The counter clears on every fall_edge and in IDLE, and increments in every other state.
  - Reaching TIMEOUT: pulse err_timeout, go to IDLE, discard the partial byte.
  - The counter saturates; it never wraps.
- Latency:
  - Push happens in the cycle the stop-bit fall_edge is evaluated.
  - rx_empty falls and rx_data is valid on the following clock edge.
  - Total latency from the physical stop-bit clock fall: 2 (sync) + FILTER + 2 cycles.
- FIFO:
  - rx_data, rx_ext and rx_rel are combinational reads of the head entry.
  - Push and pop in the same cycle is allowed even when full: the pop frees the slot and the push is accepted, with no overflow.
  - rx_rd while empty is ignored.
  - Pointers are FIFO_BITS+1 wide, giving exact full/empty detection.

Optional Feature:
PS2_RX_PREFIX_EN.
- Defined:
  - A good byte of 0xE0 sets ext_pend and a good byte of 0xF0 sets rel_pend; neither prefix byte is pushed.
  - The next good non-prefix byte is pushed as a 10-bit entry {ext_pend, rel_pend, byte}, and both pend flags then clear.
  - A byte dropped on overflow also clears the pend flags.
  - An error or timeout does not clear them.
- Undefined:
  - Every good byte is pushed, including E0 and F0.
  - rx_ext and rx_rel are tied to 0 and the FIFO is 8 bits wide.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 kHz PS/2 clock -> rx_empty falls, rx_data=0x1C, no error pulses; rx_rd pulse -> rx_empty=1.
- Same frame with parity bit 1 -> one err_parity pulse, rx_empty stays 1. Frame with stop bit 0 -> one err_frame pulse.
- Clock stops after the 4th data bit, with TIMEOUT=1000 -> err_timeout pulses 1000 cycles after the last fall. A following frame of 0x5A is then received correctly.
- 9 frames 0x01..0x09 sent with no reads -> overflow pulses exactly once, on the 9th. Reads then return 0x01..0x08 in order, then rx_empty=1.
- FIFO full; rx_rd held high in the stop-bit evaluation cycle of frame 0x33 -> no overflow. 0x33 becomes the tail and occupancy stays 8.
- With PS2_RX_PREFIX_EN: frames E0, F0, 75, then 1C -> two entries, {ext=1, rel=1, 0x75} then {ext=0, rel=0, 0x1C}. Without the feature, the same frames give four entries E0, F0, 75, 1C.
